// File: rtl/fir_tap_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fir_tap_sequencer
//
// Initiator side of the FIR tap-count handshake. One input sample is accepted
// per transaction and written into a circular delay line. The sequencer then
// runs NUM_TAPS multiply-accumulate cycles and drives the sample/coefficient
// addresses and the MAC controls. It also drives an external tap counter and
// uses that counter's flag as the end-of-taps acknowledge. The result is then
// presented with a valid/ready handshake.
//
// Transaction flow: IDLE -> CLEAR (1) -> RUN (NUM_TAPS) -> DRAIN -> OUT -> IDLE
//
// Optional feature macro: FIR_SEQ_FLAG_CHECK_EN
//   Defined   : the handshake with the tap counter is checked and a sticky err
//               is raised on a protocol violation. DRAIN then stops waiting
//               for cnt_flag, so the sequencer cannot hang.
//   Undefined : err is tied 0 and DRAIN waits for cnt_flag indefinitely.
//
// Parameters
//   ADDR_W    width of delay-line and coefficient addresses
//   NUM_TAPS  filter length, 2..256 and <= 2**ADDR_W
//   PIPE_LAT  MAC pipeline latency after the last mac_en, 0..15
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   input sample available
//   in_ready   out  sequencer can accept a sample (registered)
//   wr_en      out  delay-line write strobe (in_valid & in_ready)
//   wr_addr    out  delay-line write address
//   rd_addr    out  delay-line read address for the current tap
//   coef_addr  out  coefficient index (current tap)
//   acc_clr    out  clear accumulator
//   mac_en     out  accumulate current product
//   cnt_reset  out  tap counter reset
//   cnt_start  out  tap counter count enable
//   cnt_num    out  tap counter terminal value (NUM_TAPS-1, 8 bits)
//   cnt_flag   in   tap counter terminal flag
//   out_valid  out  filter result valid
//   out_ready  in   downstream accepts the result
//   busy       out  high in every state except IDLE
//   err        out  sticky handshake error
// -----------------------------------------------------------------------------
module fir_tap_sequencer #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned NUM_TAPS = 16,
    parameter int unsigned PIPE_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] coef_addr,
    output logic              acc_clr,
    output logic              mac_en,
    output logic              cnt_reset,
    output logic              cnt_start,
    output logic [7:0]        cnt_num,
    input  logic              cnt_flag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              err
);

    // Zero pipeline latency still needs one DRAIN cycle to sample cnt_flag.
    localparam int unsigned      DrainCyc  = (PIPE_LAT == 0) ? 1 : PIPE_LAT;
    localparam logic [3:0]       DrainLast = 4'(DrainCyc - 1);
    localparam logic [ADDR_W-1:0] LastTap  = ADDR_W'(NUM_TAPS - 1);
    localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
    localparam logic [7:0]       CntNum    = 8'(NUM_TAPS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StDrain,
        StOut
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] tap_q, tap_d;
    logic [3:0]        drain_q, drain_d;
    logic              in_ready_q, in_ready_d;

    logic              accept;
    logic              flag_ok;
    logic              in_run;
    logic [ADDR_W-1:0] rd_calc;

    assign accept = in_valid & in_ready_q;
    assign in_run = (state_q == StRun);

    // --------------------------------------------------------------------
    // Optional handshake checker. tap_q and drain_q act as the shadow of the
    // external counter: the flag must stay low through CLEAR and RUN and must
    // be high by the first DRAIN cycle.
    // --------------------------------------------------------------------
`ifdef FIR_SEQ_FLAG_CHECK_EN
    logic err_q;
    logic err_set;

    assign err_set = ((state_q == StClear || state_q == StRun) && cnt_flag) ||
                     ((state_q == StDrain) && (drain_q == 4'd0) && !cnt_flag);

    // Once an error is seen the flag is no longer trusted; DRAIN exits on its
    // own cycle count.
    assign flag_ok = cnt_flag | err_q | err_set;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign flag_ok = cnt_flag;
    assign err     = 1'b0;
`endif

    // --------------------------------------------------------------------
    // State register
    // --------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            base_q     <= '0;
            tap_q      <= '0;
            drain_q    <= 4'd0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            base_q     <= base_d;
            tap_q      <= tap_d;
            drain_q    <= drain_d;
            in_ready_q <= in_ready_d;
        end
    end

    // --------------------------------------------------------------------
    // Next-state and control outputs
    // --------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        base_d     = base_q;
        tap_d      = tap_q;
        drain_d    = drain_q;
        in_ready_d = in_ready_q;
        acc_clr    = 1'b0;
        mac_en     = 1'b0;
        cnt_reset  = 1'b0;
        cnt_start  = 1'b0;
        out_valid  = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    base_d     = wr_ptr_q;
                    wr_ptr_d   = (wr_ptr_q == LastTap) ? '0 : wr_ptr_q + AddrOne;
                    in_ready_d = 1'b0;
                    state_d    = StClear;
                end
            end

            StClear: begin
                acc_clr   = 1'b1;
                cnt_reset = 1'b1;
                tap_d     = '0;
                drain_d   = 4'd0;
                state_d   = StRun;
            end

            StRun: begin
                mac_en    = 1'b1;
                cnt_start = 1'b1;
                if (tap_q == LastTap) begin
                    tap_d   = '0;
                    state_d = StDrain;
                end else begin
                    tap_d = tap_q + AddrOne;
                end
            end

            StDrain: begin
                // Count the pipeline latency first, then wait for the flag.
                if (drain_q != DrainLast) begin
                    drain_d = drain_q + 4'd1;
                end else if (flag_ok) begin
                    drain_d = 4'd0;
                    state_d = StOut;
                end
            end

            StOut: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    in_ready_d = 1'b1;
                    state_d    = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // --------------------------------------------------------------------
    // Read address: (base - tap) mod NUM_TAPS. When tap > base the result is
    // base + (NUM_TAPS - tap), which is below NUM_TAPS and so fits ADDR_W.
    // --------------------------------------------------------------------
    always_comb begin
        if (base_q >= tap_q) begin
            rd_calc = base_q - tap_q;
        end else begin
            rd_calc = base_q + (LastTap - tap_q) + AddrOne;
        end
    end

    assign in_ready  = in_ready_q;
    assign wr_en     = accept;
    assign wr_addr   = wr_ptr_q;
    assign rd_addr   = in_run ? rd_calc : '0;
    assign coef_addr = in_run ? tap_q : '0;
    assign cnt_num   = CntNum;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_fir_tap_sequencer.sv
`timescale 1ns/1ps
// Bench for fir_tap_sequencer: randomized and directed stimulus against a
// transaction-level model that tracks the cycle offset since each accept.
module tb_fir_tap_sequencer;

    localparam int N      = 16;
    localparam int D      = 2;
    localparam int ADDR_W = 8;
`ifdef FIR_SEQ_FLAG_CHECK_EN
    localparam bit CheckEn = 1'b1;
`else
    localparam bit CheckEn = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              out_ready;
    logic              force0;
    logic              in_ready, wr_en, acc_clr, mac_en, cnt_reset, cnt_start;
    logic              out_valid, busy, err, cnt_flag;
    logic [ADDR_W-1:0] wr_addr, rd_addr, coef_addr;
    logic [7:0]        cnt_num;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_tap_sequencer #(
        .ADDR_W  (ADDR_W),
        .NUM_TAPS(N),
        .PIPE_LAT(D)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .coef_addr(coef_addr),
        .acc_clr  (acc_clr),
        .mac_en   (mac_en),
        .cnt_reset(cnt_reset),
        .cnt_start(cnt_start),
        .cnt_num  (cnt_num),
        .cnt_flag (cnt_flag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .err      (err)
    );

    // Well-behaved external tap counter: flag once NUM_TAPS counts are done.
    int cnt_q;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)       cnt_q <= 0;
        else if (cnt_reset) cnt_q <= 0;
        else if (cnt_start) cnt_q <= cnt_q + 1;
    end
    assign cnt_flag = !force0 && !cnt_reset && (cnt_q == N);

    // ---------------- reference model ----------------
    // m_k = cycles since the accept edge: 1 clear, 2..N+1 run, then drain, then out.
    bit m_idle, m_rdy, m_err;
    int m_k, m_wr, m_base;
    bit e_busy, e_in_ready, e_wr_en, e_acc_clr, e_run, e_out, e_err, m_stuck;
    int e_tap, e_rd;

    always_comb begin
        m_stuck    = force0 && !CheckEn;
        e_busy     = !m_idle;
        e_in_ready = m_idle && m_rdy;
        e_wr_en    = e_in_ready && in_valid;
        e_acc_clr  = !m_idle && (m_k == 1);
        e_run      = !m_idle && (m_k >= 2) && (m_k <= N + 1);
        e_tap      = m_k - 2;
        e_rd       = (m_base - e_tap + N) % N;
        e_out      = !m_idle && !m_stuck && (m_k >= N + 2 + D);
        e_err      = m_err;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_idle <= 1'b1; m_rdy <= 1'b0; m_err <= 1'b0;
            m_k <= 0; m_wr <= 0; m_base <= 0;
        end else if (m_idle) begin
            if (m_rdy && in_valid) begin
                m_idle <= 1'b0; m_k <= 1; m_base <= m_wr;
                m_wr <= (m_wr + 1) % N; m_rdy <= 1'b0;
            end else begin
                m_rdy <= 1'b1;
            end
        end else begin
            if (e_out && out_ready) begin
                m_idle <= 1'b1; m_rdy <= 1'b1; m_k <= 0;
            end else if (m_k < 100000) begin
                m_k <= m_k + 1;
            end
            if (CheckEn && force0 && m_k == N + 2) m_err <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- compare process and monitors ----------------
    int   acc_cyc = 0, busy_fall = 0, run_idx = 0, n_acc = 0, n_hs = 0;
    int   last_wr = -1;
    int   coef_tr[256];
    int   rd_tr[256];
    logic prev_ov = 1'b0, prev_busy = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            check("busy",      32'(busy),      32'(e_busy));
            check("in_ready",  32'(in_ready),  32'(e_in_ready));
            check("wr_en",     32'(wr_en),     32'(e_wr_en));
            check("acc_clr",   32'(acc_clr),   32'(e_acc_clr));
            check("cnt_reset", 32'(cnt_reset), 32'(e_acc_clr));
            check("mac_en",    32'(mac_en),    32'(e_run));
            check("cnt_start", 32'(cnt_start), 32'(e_run));
            check("out_valid", 32'(out_valid), 32'(e_out));
            check("err",       32'(err),       32'(e_err));
            check("cnt_num",   32'(cnt_num),   32'(N - 1));
            check("rdy_busy",  32'(in_ready & busy), 32'(0));
            if (e_wr_en) check("wr_addr", 32'(wr_addr), 32'(m_wr));
            if (e_run) begin
                check("coef_addr", 32'(coef_addr), 32'(e_tap));
                check("rd_addr",   32'(rd_addr),   32'(e_rd));
            end
            if (wr_en) begin
                acc_cyc = cyc; last_wr = int'(wr_addr); n_acc++; run_idx = 0;
            end
            if (mac_en && run_idx < 256) begin
                coef_tr[run_idx] = int'(coef_addr);
                rd_tr[run_idx]   = int'(rd_addr);
                run_idx++;
            end
            if (out_valid && !prev_ov) check("latency", 32'(cyc - acc_cyc), 32'(20));
            if (out_valid && out_ready) n_hs++;
            if (!busy && prev_busy) busy_fall = cyc;
            prev_ov   = out_valid;
            prev_busy = busy;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle(input int maxc);
        int i = 0;
        while (!(m_idle && m_rdy) && i < maxc) begin
            @(posedge clk); #1; i++;
        end
        @(posedge clk); #1;
        check("idle_reached", 32'(busy), 32'(0));
    endtask

    task automatic accept_one();
        int i = 0;
        while (!(m_idle && m_rdy) && i < 200) begin
            @(posedge clk); #1; i++;
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int hs0, a0, g;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; force0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_busy",     32'(busy),     32'(0));
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_rst", 32'(in_ready), 32'(1));

        // Single sample with defaults
        out_ready = 1'b1;
        accept_one();
        wait_idle(100);
        check("t1_wr_addr",    32'(last_wr), 32'(0));
        check("t1_mac_cycles", 32'(run_idx), 32'(16));
        check("t1_coef_first", 32'(coef_tr[0]), 32'(0));
        check("t1_coef_last",  32'(coef_tr[15]), 32'(15));
        check("t1_busy_fall",  32'(busy_fall - acc_cyc), 32'(21));

        // Second sample: read addresses wrap below zero
        accept_one();
        wait_idle(100);
        check("t2_wr_addr", 32'(last_wr), 32'(1));
        check("t2_rd0",  32'(rd_tr[0]),  32'(1));
        check("t2_rd1",  32'(rd_tr[1]),  32'(0));
        check("t2_rd2",  32'(rd_tr[2]),  32'(15));
        check("t2_rd15", 32'(rd_tr[15]), 32'(2));

        // 17 back-to-back samples; write pointer wraps 15 -> 0
        hs0 = n_hs; a0 = n_acc; g = 0;
        in_valid = 1'b1;
        while (n_acc < a0 + 17 && g < 2000) begin
            @(posedge clk); #1; g++;
        end
        in_valid = 1'b0;
        wait_idle(200);
        check("t3_accepts", 32'(n_acc - a0), 32'(17));
        check("t3_pulses",  32'(n_hs - hs0), 32'(17));
        check("t3_last_wr", 32'(last_wr),    32'(2));

        // Downstream stall in OUT
        out_ready = 1'b0;
        accept_one();
        g = 0;
        while (!e_out && g < 100) begin
            @(posedge clk); #1; g++;
        end
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("t4_hold_valid", 32'(out_valid), 32'(1));
        check("t4_hold_rdy",   32'(in_ready),  32'(0));
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_idle", 32'(busy), 32'(0));
        wait_idle(50);

        // Reset in the middle of RUN (tap 7)
        hs0 = n_hs;
        accept_one();
        g = 0;
        while (m_k != 9 && g < 50) begin
            @(posedge clk); #1; g++;
        end
        check("t5_tap", 32'(coef_addr), 32'(7));
        reset_n = 1'b0;
        #1;
        check("t5_rst_mac",  32'(mac_en),    32'(0));
        check("t5_rst_busy", 32'(busy),      32'(0));
        check("t5_rst_cnt",  32'(cnt_start), 32'(0));
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
        end
        check("t5_no_out", 32'(n_hs - hs0), 32'(0));
        accept_one();
        check("t5_wr_addr", 32'(last_wr), 32'(0));
        wait_idle(100);

        // Randomized traffic with occasional resets
        repeat (3000) begin
            in_valid  = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0; #2; reset_n = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        wait_idle(200);

        // Counter never raises its flag
        force0 = 1'b1;
        accept_one();
`ifdef FIR_SEQ_FLAG_CHECK_EN
        wait_idle(100);
        check("t7_err", 32'(err), 32'(1));
`else
        repeat (N + D + 20) begin
            @(posedge clk); #1;
        end
        check("t7_stuck_busy", 32'(busy),      32'(1));
        check("t7_no_out",     32'(out_valid), 32'(0));
`endif
        reset_n = 1'b0; force0 = 1'b0;
        #1;
        check("t7_rst_err",  32'(err),  32'(0));
        check("t7_rst_busy", 32'(busy), 32'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
- Initiator side of the FIR tap-count handshake.
- Accepts one input sample per transaction and writes it into the circular delay line.
- Sequences NUM_TAPS multiply-accumulate cycles, generating sample and coefficient addresses and MAC controls.
- Drives the tap counter (cnt_reset/cnt_start/cnt_num), uses its returned flag as the end-of-taps acknowledge, then presents the filter result with a valid/ready handshake.

Parameters:
- ADDR_W, 8, width of delay-line and coefficient addresses.
- NUM_TAPS, 16, filter length. Legal range 2..256, and NUM_TAPS <= 2^ADDR_W.
- PIPE_LAT, 2, MAC pipeline latency in cycles from the last mac_en to a valid accumulator. Legal range 0..15.

Ports:
- clk, in, 1: rising-edge clock.
- reset_n, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: input sample available.
- in_ready, out, 1: sequencer can accept a sample.
- wr_en, out, 1: delay-line write strobe (= in_valid & in_ready).
- wr_addr, out, ADDR_W: delay-line write address (wr_ptr).
- rd_addr, out, ADDR_W: delay-line read address for the current tap.
- coef_addr, out, ADDR_W: coefficient index (tap).
- acc_clr, out, 1: clear accumulator.
- mac_en, out, 1: accumulate the current product.
- cnt_reset, out, 1: tap counter reset.
- cnt_start, out, 1: tap counter count enable.
- cnt_num, out, 8: tap counter terminal value, constant NUM_TAPS-1.
- cnt_flag, in, 1: tap counter terminal flag.
- out_valid, out, 1: filter result valid.
- out_ready, in, 1: downstream accepts the result.
- busy, out, 1: high in every state except IDLE.
- err, out, 1: sticky handshake error (see Optional Feature).

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, wr_ptr=0, base=0, tap=0, drain count=0.
  - All outputs 0 except cnt_num.
  - in_ready is a registered output: 0 during reset, 1 from the first clk edge after reset_n rises.
  - Reset mid-operation aborts immediately; no out_valid is produced for the aborted sample.
- Address wrap: all address arithmetic is modulo NUM_TAPS, not 2^ADDR_W.
- IDLE:
  - Accept when in_valid & in_ready at a clk edge. In that cycle wr_en=1 and wr_addr=wr_ptr.
  - On the accept edge: base<=wr_ptr; wr_ptr<=wr_ptr+1, wrapping NUM_TAPS-1 -> 0; in_ready<=0; go to CLEAR.
- CLEAR (1 cycle): acc_clr=1, cnt_reset=1, tap=0. Go to RUN.
- RUN (exactly NUM_TAPS cycles):
  - mac_en=1, cnt_start=1, coef_addr=tap, rd_addr=(base-tap) mod NUM_TAPS.
  - tap increments each cycle. When tap==NUM_TAPS-1, go to DRAIN.
- DRAIN:
  - mac_en=0 and cnt_start=0.
  - Counts max(PIPE_LAT,1) cycles, then also waits for cnt_flag==1. cnt_flag is expected high from the first DRAIN cycle.
  - When both conditions hold, go to OUT.
- OUT:
  - out_valid=1, held stable until out_ready.
  - On the out_valid & out_ready edge: out_valid<=0, in_ready<=1, go to IDLE.
  - There is no same-cycle re-accept: the next accept is possible one cycle after the handshake.
- Latency with defaults: accept at cycle 0 -> CLEAR at cycle 1 -> RUN at cycles 2..17 -> DRAIN at cycles 18..19 -> out_valid at cycle 20.
- cnt_num = NUM_TAPS-1, truncated to 8 bits.
- in_valid while in_ready=0 is ignored; the sample is not written.

Optional Feature:
- Macro: FIR_SEQ_FLAG_CHECK_EN.
- Defined:
  - A shadow tap counter checks the handshake.
  - Error conditions: cnt_flag==1 during any CLEAR or RUN cycle, or cnt_flag==0 on the first DRAIN cycle.
  - On error, err<=1 (sticky until reset).
  - DRAIN then ignores cnt_flag and exits after max(PIPE_LAT,1) cycles, so the sequencer never hangs.
- Undefined: err is tied 0, and DRAIN waits indefinitely for cnt_flag.

Test Plan:
- Single sample, defaults, counter model responding correctly, out_ready=1:
  - wr_en at cycle 0 with wr_addr=0.
  - acc_clr at cycle 1.
  - 16 mac_en cycles, coef_addr 0..15.
  - out_valid at cycle 20. busy is 0 at cycle 21.
- Second sample: wr_addr=1; RUN rd_addr sequence 1,0,15,14,...,2 (wrap below 0).
- 17 back-to-back samples: wr_addr wraps 15 -> 0. Exactly 17 out_valid pulses. in_ready never high while busy.
- out_ready held 0 for 5 cycles in OUT: out_valid stays 1 and in_ready stays 0; on release, IDLE follows one cycle later.
- reset_n pulsed low mid-RUN (tap=7): outputs clear asynchronously, no out_valid, next accept uses wr_addr=0.
- With FIR_SEQ_FLAG_CHECK_EN, cnt_flag forced 0: err=1 at the second DRAIN cycle and out_valid at cycle 20. Without the macro, the sequencer stays in DRAIN with busy=1.
